// File: rtl/nand_logic_selftest.sv
`default_nettype none
// ============================================================================
// Module      : nand_logic_selftest
// Description : WIDTH-bit bitwise logic unit (OR/AND/NOR/XOR) built only from
//               2-input NAND primitives, checked on-chip against a behavioural
//               control path. A start pulse launches an exhaustive sweep of all
//               2^(2*WIDTH) operand pairs through a 2-stage pipeline. Mismatches
//               are counted (saturating), the first failing operands are kept,
//               and pass/fail is reported.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               start      - begin sweep (honoured in IDLE or DONE only)
//               mode       - 00=OR 01=AND 10=NOR 11=XOR, latched on start
//               fault_inj  - live inversion of NAND-path bit 0 (self-test)
//               busy       - sweep in progress (RUN or FLUSH)
//               done       - sweep finished, held until the next start
//               pass       - done with zero mismatches
//               vec_a/b    - operands currently applied (stage 1)
//               s_nand     - registered NAND-path result (stage 2)
//               s_ctrl     - registered control-path result (stage 2)
//               err_count  - saturating count of mismatching vectors
//               fail_a/b   - operands of the first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module nand_logic_selftest #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             fault_inj,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] vec_a,
    output logic [WIDTH-1:0] vec_b,
    output logic [WIDTH-1:0] s_nand,
    output logic [WIDTH-1:0] s_ctrl,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int               VW      = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [VW-1:0]    vec;          // {vec_a, vec_b} sweep counter (stage 1)
    logic             v1, v2;       // stage valid flags
    logic [1:0]       mode_q;
    logic             mis2;         // stage-2 mismatch
    logic [WIDTH-1:0] a2, b2;       // stage-2 operands for first-fail capture
    logic             launch;

    logic [WIDTH-1:0] or_v, and_v, nor_v, xor_v;
    logic [WIDTH-1:0] nand_res, nand_fin, ctrl_res;

    assign vec_a = vec[VW-1:WIDTH];
    assign vec_b = vec[WIDTH-1:0];

    // ------------------------------------------------------------------------
    // NAND-only per-bit logic
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic n_a, n_b, n_ab, x_t1, x_t2;
        assign n_a      = ~(vec_a[i] & vec_a[i]);    // NOT a
        assign n_b      = ~(vec_b[i] & vec_b[i]);    // NOT b
        assign n_ab     = ~(vec_a[i] & vec_b[i]);
        assign or_v[i]  = ~(n_a & n_b);
        assign and_v[i] = ~(n_ab & n_ab);
        assign nor_v[i] = ~(or_v[i] & or_v[i]);
        // Classic 4-NAND XOR sharing the NAND(a,b) term
        assign x_t1     = ~(vec_a[i] & n_ab);
        assign x_t2     = ~(vec_b[i] & n_ab);
        assign xor_v[i] = ~(x_t1 & x_t2);
    end

    always_comb begin
        nand_res = or_v;
        case (mode_q)
            2'b00:   nand_res = or_v;
            2'b01:   nand_res = and_v;
            2'b10:   nand_res = nor_v;
            default: nand_res = xor_v;
        endcase
        nand_fin    = nand_res;
        nand_fin[0] = nand_res[0] ^ fault_inj;
    end

    // Behavioural reference path
    always_comb begin
        ctrl_res = vec_a | vec_b;
        case (mode_q)
            2'b00:   ctrl_res = vec_a | vec_b;
            2'b01:   ctrl_res = vec_a & vec_b;
            2'b10:   ctrl_res = ~(vec_a | vec_b);
            default: ctrl_res = vec_a ^ vec_b;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    assign launch = ((state == IDLE) || (state == DONE)) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (&vec)  state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    // ------------------------------------------------------------------------
    // Datapath: vector counter, stage-2 register, error accounting
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            mode_q    <= 2'b00;
            s_nand    <= '0;
            s_ctrl    <= '0;
            mis2      <= 1'b0;
            a2        <= '0;
            b2        <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
        end else begin
            // Stage 1
            if (launch) begin
                mode_q <= mode;
                vec    <= '0;
                v1     <= 1'b1;
            end else if (state == RUN) begin
                if (&vec) v1  <= 1'b0;            // last vector: hold and drain
                else      vec <= vec + 1'b1;
            end

            // Stage 2 only captures valid vectors so results hold in DONE
            v2 <= v1;
            if (v1) begin
                s_nand <= nand_fin;
                s_ctrl <= ctrl_res;
                mis2   <= (nand_fin != ctrl_res);
                a2     <= vec_a;
                b2     <= vec_b;
            end

            // Error accounting
            if (launch) begin
                err_count <= '0;
                fail_a    <= '0;
                fail_b    <= '0;
            end else if (v2 && mis2) begin
                if (err_count == '0) begin
                    fail_a <= a2;
                    fail_b <= b2;
                end
                if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/nand_logic_selftest.md
Name: nand_logic_selftest

Overview:
- Parametrised, self-sequencing successor to the single-bit NAND-only OR cell.
- Builds a WIDTH-bit, bitwise logic unit from 2-input NAND primitives only. The unit has four modes.
- A behavioural control model runs alongside it. The block sweeps every operand combination, compares the two models each cycle, counts mismatches, and reports pass/fail.
- Replaces the hand-written x/y stimulus and monitor bench with on-chip exhaustive checking.

Parameters:
- WIDTH, 4, bits per operand; the sweep covers 2^(2*WIDTH) vectors.
- CNT_W, 16, width of the mismatch counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE or DONE
- mode  input  2  00=OR, 01=AND, 10=NOR, 11=XOR; latched on start
- fault_inj  input  1  when 1, inverts bit 0 of the NAND-path result (checker self-test); sampled live
- busy  output  1  high in RUN and FLUSH
- done  output  1  high in DONE until the next start
- pass  output  1  done && err_count==0
- vec_a  output  WIDTH  operand A currently applied
- vec_b  output  WIDTH  operand B currently applied
- s_nand  output  WIDTH  registered NAND-path result (stage 2)
- s_ctrl  output  WIDTH  registered control-path result (stage 2)
- err_count  output  CNT_W  mismatching vectors, saturating
- fail_a  output  WIDTH  operand A of the first mismatch
- fail_b  output  WIDTH  operand B of the first mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0 (busy, done, pass, vec_a, vec_b, s_nand, s_ctrl, err_count, fail_a, fail_b). Stage valid flags are cleared and the latched mode is set to 00.
- Reset mid-run aborts immediately. After release the block stays in IDLE until the next start.
- NAND path, per bit, NAND gates only:
  - OR = NAND(NOT a, NOT b)
  - AND = NOT NAND(a,b)
  - NOR = NOT OR
  - XOR = 4-NAND form
  - NOT x = NAND(x,x)
- Control path is behavioural (|, &, ~|, ^).
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE/DONE, start=1: latch mode; clear err_count, fail_a, fail_b and done; {vec_a,vec_b}=0; stage-1 valid=1; go to RUN.
  - RUN: each edge {vec_a,vec_b} increments by 1 ({vec_a,vec_b} is a 2*WIDTH-bit counter, vec_a in the high half). When the counter is all-ones at the edge, go to FLUSH; the counter holds and stage-1 valid drops.
  - FLUSH: one cycle, then DONE.
  - DONE: done=1 and the vector outputs hold. A new start restarts the sweep.
- start while busy is ignored. mode changes while busy are ignored.
- Pipeline, 2 stages:
  - Stage 1 is the registered vector.
  - Stage 2 registers s_nand, s_ctrl and mismatch=(s_nand!=s_ctrl) one edge later.
  - err_count increments on the edge after stage 2 holds a valid mismatch, saturating at 2^CNT_W-1.
- The vector applied at start edge + k is counted at start edge + k + 2.
- Sweep length: done rises on start edge + 2^(2*WIDTH) + 1. The final count is valid on that same edge.
- First failure: fail_a/fail_b capture the stage-2 operands of the first mismatch, only while err_count==0, and then hold.
- fault_inj toggled mid-run affects only the vectors evaluated while it is high.

Test Plan:
- WIDTH=2, mode=00, start one cycle -> busy high for 17 cycles; done/pass=1 on start edge+17; err_count=0; s_nand==s_ctrl every valid cycle.
- WIDTH=2, each mode 01/10/11 in turn -> pass=1 each time. For vec_a=2'b01, vec_b=2'b11, s_nand equals 01 (AND), 00 (NOR), 10 (XOR).
- WIDTH=2, fault_inj=1 for the whole sweep -> err_count=16, pass=0, fail_a=fail_b=0.
- WIDTH=2, CNT_W=4, fault_inj=1 -> err_count saturates at 15 and does not wrap.
- Assert rst_n=0 at cycle 6 of a run -> all outputs 0 immediately; start after release gives a full clean sweep with err_count=0.
- start pulsed and mode changed mid-run -> no restart; the latched mode is used; done on the original schedule. start in DONE -> done clears on the next edge and a new sweep begins.
